execute_unit: RTL and testbench
===============================

// Module: execute_unit
// PURPOSE
//  Execute stage directly downstream of the register file. Consumes the two read operands plus the decoded op.
//  Produces the write-back triple (reg_write, write_reg, write_data) that returns to the register file.
//  Single-cycle ALU ops plus an iterative shift-add multiplier and restoring divider, under a valid/ready input handshake.
// PARAMETERS
//  WIDTH       24  datapath width (operands, result)
//  REG_ADDR_W   2  register address width (4 registers)
// PORTS
//  clock       in   1           single clock; all state updates on posedge
//  reset       in   1           synchronous, active-high
//  in_valid    in   1           op/operands valid this cycle
//  in_ready    out  1           unit can accept; transfer = in_valid & in_ready at posedge
//  alu_op      in   4           operation code (see BEHAVIOUR)
//  operand_a   in   WIDTH       from read_data_1
//  operand_b   in   WIDTH       from read_data_2
//  dest_reg    in   REG_ADDR_W  destination register
//  wb_en       in   1           instruction writes back
//  out_valid   out  1           one-cycle pulse: result valid
//  write_data  out  WIDTH       result
//  write_reg   out  REG_ADDR_W  registered dest_reg
//  reg_write   out  1           = out_valid & wb_en & (write_reg != 0) & !illegal_op
//  zero        out  1           write_data == 0, qualified by out_valid
//  illegal_op  out  1           pulse with out_valid for reserved/disabled op
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid/reg_write/zero/illegal_op=0, write_data=0, write_reg=0.
//  - Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU.
//  - Shifts: 8 SLL, 9 SRL, A SRA; shamt=operand_b[4:0]; shamt>=WIDTH -> 0 (SRA: sign fill).
//  - Multi-cycle: B MUL (low WIDTH bits of product), C DIVU quotient, D REMU remainder.
//  - Reserved: E, F.
//  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag. SLT/SLTU result is 0 or 1.
//  - FSM: IDLE, RUN. in_ready = (state==IDLE).
//  - IDLE, single-cycle op accepted at edge N: write_data/out_valid appear after edge N (latency 1).
//    Back-to-back accepts give consecutive out_valid pulses.
//  - IDLE, MUL/DIVU/REMU accepted at edge N: latch operands, count=WIDTH-1, go RUN; out_valid=0.
//  - RUN: one iteration per edge. At the edge with count==0: register result, out_valid=1, go IDLE.
//    Result appears after edge N+WIDTH; in_ready is low for WIDTH cycles.
//  - in_valid is ignored while RUN; the upstream stage holds its inputs.
//  - Divide by zero: quotient = all ones (0xFFFFFF); remainder = dividend. Same WIDTH-cycle latency.
//  - Reserved op: single-cycle, write_data=0, illegal_op=1, reg_write=0.
//  - dest_reg==0: result still produced; reg_write=0 (register 0 reads as zero).
//  - reset during RUN: abort; the next cycle is IDLE; no out_valid, no write-back.
//  - Outputs hold their last value except the pulses (out_valid, reg_write, zero, illegal_op), which deassert after one cycle.
// CONFIGURATION
//  ALU_DIV_EN defined: DIVU/REMU implemented as above.
//  ALU_DIV_EN undefined: codes C/D are reserved (single-cycle, result 0, illegal_op=1, reg_write=0).
//    No divider logic is synthesised; MUL is unaffected.
// TESTING
//  1. ADD 0xFFFFFF+2, dest 1 -> one cycle later: write_data=0x000001, reg_write=1, write_reg=1.
//  2. SLT a=0xFFFFFF b=1 -> 1; SLTU same operands -> 0, zero=1.
//  3. MUL 1000*3000 accepted at edge 0 -> in_ready=0 for 24 cycles.
//     out_valid after edge 24, write_data=0x2DC6C0.
//  4. DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 55/0 -> 0xFFFFFF; REMU 55/0 -> 55.
//     Without ALU_DIV_EN: DIVU 100/7 -> illegal_op=1, write_data=0, reg_write=0.
//  5. reset asserted 10 cycles into MUL -> next cycle in_ready=1, out_valid stays 0.
//     Then ADD 3+4 -> 7.
//  6. ADD with dest_reg=0 -> out_valid=1, reg_write=0.
//     Three back-to-back ADDs -> three consecutive out_valid pulses.

Source files
------------

// File: rtl/execute_unit_if.sv
// Handshake/bus bundle between the register-file read stage and execute_unit.
// The master drives the op and operands; the slave returns the write-back triple and flags.
interface execute_unit_if #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned REG_ADDR_W = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            alu_op;
  logic [WIDTH-1:0]      operand_a;
  logic [WIDTH-1:0]      operand_b;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic                  wb_en;
  logic                  out_valid;
  logic [WIDTH-1:0]      write_data;
  logic [REG_ADDR_W-1:0] write_reg;
  logic                  reg_write;
  logic                  zero;
  logic                  illegal_op;

  modport master (
    output in_valid, alu_op, operand_a, operand_b, dest_reg, wb_en,
    input  in_ready, out_valid, write_data, write_reg, reg_write, zero, illegal_op
  );

  modport slave (
    input  in_valid, alu_op, operand_a, operand_b, dest_reg, wb_en,
    output in_ready, out_valid, write_data, write_reg, reg_write, zero, illegal_op
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops plus iterative shift-add MUL and restoring DIVU/REMU.
// Define ALU_DIV_EN to build the divider; otherwise opcodes C/D are reserved.
module execute_unit #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned REG_ADDR_W = 2
) (
  input logic          clock,
  input logic          reset,
  execute_unit_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(WIDTH);
  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_DIVU = 4'hC;
  localparam logic [3:0] OP_REMU = 4'hD;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  wb_q, wb_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [WIDTH-1:0]      write_data_q, write_data_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic                  out_valid_q, out_valid_d;
  logic                  reg_write_q, reg_write_d;
  logic                  zero_q, zero_d;
  logic                  illegal_q, illegal_d;
`ifdef ALU_DIV_EN
  logic                  div_q, div_d;
  logic                  rem_sel_q, rem_sel_d;
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]      quo_q, quo_d;
  logic [WIDTH-1:0]      divisor_q, divisor_d;
  logic [WIDTH:0]        div_r_c, div_diff_c;
  logic                  div_ge_c;
`endif

  logic [SHAMT_W-1:0]    shamt_c;
  logic                  shift_big_c;
  logic [WIDTH-1:0]      alu_res_c;
  logic                  alu_ill_c;
  logic                  is_multi_c;
  logic [WIDTH-1:0]      mul_acc_c;
  logic                  fin_c;
  logic [WIDTH-1:0]      fin_data_c;
  logic                  fin_ill_c;
  logic [REG_ADDR_W-1:0] fin_dest_c;
  logic                  fin_wb_c;

  // Single-cycle result and op classification straight from the inputs
  always_comb begin
    shamt_c     = bus.operand_b[SHAMT_W-1:0];
    shift_big_c = (32'(shamt_c) >= WIDTH);
    alu_res_c   = '0;
    alu_ill_c   = 1'b0;
    is_multi_c  = (bus.alu_op == OP_MUL);
    case (bus.alu_op)
      OP_ADD:  alu_res_c = bus.operand_a + bus.operand_b;
      OP_SUB:  alu_res_c = bus.operand_a - bus.operand_b;
      OP_AND:  alu_res_c = bus.operand_a & bus.operand_b;
      OP_OR:   alu_res_c = bus.operand_a | bus.operand_b;
      OP_XOR:  alu_res_c = bus.operand_a ^ bus.operand_b;
      OP_NOR:  alu_res_c = ~(bus.operand_a | bus.operand_b);
      OP_SLT:  alu_res_c = WIDTH'($signed(bus.operand_a) < $signed(bus.operand_b));
      OP_SLTU: alu_res_c = WIDTH'(bus.operand_a < bus.operand_b);
      OP_SLL:  alu_res_c = shift_big_c ? '0 : (bus.operand_a << shamt_c);
      OP_SRL:  alu_res_c = shift_big_c ? '0 : (bus.operand_a >> shamt_c);
      OP_SRA:  alu_res_c = shift_big_c ? {WIDTH{bus.operand_a[WIDTH-1]}}
                                       : WIDTH'($signed(bus.operand_a) >>> shamt_c);
      OP_MUL:  alu_res_c = '0;
`ifdef ALU_DIV_EN
      OP_DIVU, OP_REMU: begin
        alu_res_c  = '0;
        is_multi_c = 1'b1;
      end
`endif
      default: alu_ill_c = 1'b1;
    endcase
  end

  // Next-state, iteration datapath and registered-output values
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    dest_d       = dest_q;
    wb_d         = wb_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    out_valid_d  = 1'b0;
    reg_write_d  = 1'b0;
    zero_d       = 1'b0;
    illegal_d    = 1'b0;
    fin_c        = 1'b0;
    fin_data_c   = '0;
    fin_ill_c    = 1'b0;
    fin_dest_c   = dest_q;
    fin_wb_c     = wb_q;
    mul_acc_c    = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef ALU_DIV_EN
    div_d        = div_q;
    rem_sel_d    = rem_sel_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    divisor_d    = divisor_q;
    // Borrow out of the trial subtraction decides the quotient bit
    div_r_c      = {rem_q, quo_q[WIDTH-1]};
    div_diff_c   = div_r_c - {1'b0, divisor_q};
    div_ge_c     = ~div_diff_c[WIDTH];
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_multi_c) begin
            state_d  = RUN;
            count_d  = CNT_W'(WIDTH - 1);
            dest_d   = bus.dest_reg;
            wb_d     = bus.wb_en;
            acc_d    = '0;
            mcand_d  = bus.operand_a;
            mplier_d = bus.operand_b;
`ifdef ALU_DIV_EN
            div_d     = (bus.alu_op != OP_MUL);
            rem_sel_d = (bus.alu_op == OP_REMU);
            rem_d     = '0;
            quo_d     = bus.operand_a;
            divisor_d = bus.operand_b;
`endif
          end else begin
            fin_c      = 1'b1;
            fin_data_c = alu_res_c;
            fin_ill_c  = alu_ill_c;
            fin_dest_c = bus.dest_reg;
            fin_wb_c   = bus.wb_en;
          end
        end
      end
      RUN: begin
        acc_d    = mul_acc_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`ifdef ALU_DIV_EN
        rem_d    = div_ge_c ? div_diff_c[WIDTH-1:0] : div_r_c[WIDTH-1:0];
        quo_d    = {quo_q[WIDTH-2:0], div_ge_c};
`endif
        if (count_q == '0) begin
          state_d    = IDLE;
          fin_c      = 1'b1;
          fin_data_c = mul_acc_c;
`ifdef ALU_DIV_EN
          if (div_q) fin_data_c = rem_sel_q ? rem_d : quo_d;
`endif
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin_c) begin
      out_valid_d  = 1'b1;
      write_data_d = fin_data_c;
      write_reg_d  = fin_dest_c;
      illegal_d    = fin_ill_c;
      zero_d       = (fin_data_c == '0);
      reg_write_d  = fin_wb_c && (fin_dest_c != '0) && !fin_ill_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      dest_q       <= '0;
      wb_q         <= 1'b0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      write_data_q <= '0;
      write_reg_q  <= '0;
      out_valid_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      zero_q       <= 1'b0;
      illegal_q    <= 1'b0;
`ifdef ALU_DIV_EN
      div_q        <= 1'b0;
      rem_sel_q    <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      divisor_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      dest_q       <= dest_d;
      wb_q         <= wb_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      out_valid_q  <= out_valid_d;
      reg_write_q  <= reg_write_d;
      zero_q       <= zero_d;
      illegal_q    <= illegal_d;
`ifdef ALU_DIV_EN
      div_q        <= div_d;
      rem_sel_q    <= rem_sel_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      divisor_q    <= divisor_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.write_data = write_data_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.zero       = zero_q;
  assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: behavioural model + scoreboard checked every cycle,
// plus directed cases with hand-computed results.
module tb_execute_unit;
  localparam int unsigned W  = 24;
  localparam int unsigned RW = 2;
  localparam logic [W-1:0] MASK = {W{1'b1}};
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_unit_if #(.WIDTH(W), .REG_ADDR_W(RW)) bus ();
  execute_unit #(.WIDTH(W), .REG_ADDR_W(RW)) dut (.clock(clk), .reset(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference semantics in plain 64-bit arithmetic
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ill, output bit multi);
    longint unsigned ua, ub;
    longint          sa, sb;
    int              sh;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = '0; ill = 1'b0; multi = 1'b0;
    case (op)
      4'h0: r = W'(ua + ub);
      4'h1: r = W'(ua - ub);
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~(a | b);
      4'h6: r = W'(sa < sb);
      4'h7: r = W'(ua < ub);
      4'h8: r = W'(ua << sh);
      4'h9: r = W'(ua >> sh);
      4'hA: r = W'(sa >>> sh);
      4'hB: begin multi = 1'b1; r = W'(ua * ub); end
      4'hC: if (DIV_EN) begin multi = 1'b1; r = (ub == 0) ? MASK : W'(ua / ub); end
            else ill = 1'b1;
      4'hD: if (DIV_EN) begin multi = 1'b1; r = (ub == 0) ? a : W'(ua % ub); end
            else ill = 1'b1;
      default: ill = 1'b1;
    endcase
  endfunction

  typedef struct {
    int            due;
    logic [W-1:0]  data;
    logic [RW-1:0] wreg;
    logic          rw;
    logic          ill;
  } exp_t;

  exp_t          sbq[$];
  int            cyc = 0;
  int            busy_until = 0;
  logic [W-1:0]  last_data = '0;
  logic [RW-1:0] last_wreg = '0;

  // Acceptance model: records what each accepted op must produce and when
  always @(posedge clk) begin : model_p
    int           pre;
    logic [W-1:0] r;
    logic         ill;
    bit           multi;
    exp_t         e;
    pre = cyc;
    cyc = cyc + 1;
    if (rst) begin
      sbq.delete();
      busy_until = cyc;
      last_data  = '0;
      last_wreg  = '0;
    end else if (bus.in_valid && pre >= busy_until) begin
      model(bus.alu_op, bus.operand_a, bus.operand_b, r, ill, multi);
      e.due  = multi ? cyc + int'(W) : cyc;
      e.data = r;
      e.wreg = bus.dest_reg;
      e.ill  = ill;
      e.rw   = bus.wb_en && (bus.dest_reg != '0) && !ill;
      sbq.push_back(e);
      busy_until = e.due;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin : cmp_p
    exp_t e;
    bit   ev;
    if (cyc > 0) begin
      ev = 1'b0;
      if (sbq.size() > 0) ev = (sbq[0].due == cyc);
      if (ev) begin
        e = sbq.pop_front();
        chk("sb_out_valid", W'(bus.out_valid), W'(1));
        chk("sb_write_data", bus.write_data, e.data);
        chk("sb_write_reg", W'(bus.write_reg), W'(e.wreg));
        chk("sb_reg_write", W'(bus.reg_write), W'(e.rw));
        chk("sb_zero", W'(bus.zero), W'(e.data == '0));
        chk("sb_illegal_op", W'(bus.illegal_op), W'(e.ill));
        last_data = e.data;
        last_wreg = e.wreg;
      end else begin
        chk("sb_idle_out_valid", W'(bus.out_valid), W'(0));
        chk("sb_idle_reg_write", W'(bus.reg_write), W'(0));
        chk("sb_idle_zero", W'(bus.zero), W'(0));
        chk("sb_idle_illegal", W'(bus.illegal_op), W'(0));
        chk("sb_hold_data", bus.write_data, last_data);
        chk("sb_hold_reg", W'(bus.write_reg), W'(last_wreg));
      end
      chk("sb_in_ready", W'(bus.in_ready), W'(cyc >= busy_until));
    end
  end

  // Called at a negedge; issues one op and returns at the following negedge
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [RW-1:0] d, input logic wb);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout: in_ready stuck at 0 after %0d cycles", n);
    end
    bus.in_valid  = 1'b1;
    bus.alu_op    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_reg  = d;
    bus.wb_en     = wb;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [RW-1:0] d, input logic wb,
                     input logic [W-1:0] ed, input logic erw, input logic eill, output int busy);
    int n = 0;
    busy = 0;
    send(op, a, b, d, wb);
    while (!bus.out_valid && n < 40) begin
      if (!bus.in_ready) busy++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_out_valid"}, W'(bus.out_valid), W'(1));
    chk({nm, "_data"}, bus.write_data, ed);
    chk({nm, "_write_reg"}, W'(bus.write_reg), W'(d));
    chk({nm, "_reg_write"}, W'(bus.reg_write), W'(erw));
    chk({nm, "_illegal"}, W'(bus.illegal_op), W'(eill));
    chk({nm, "_zero"}, W'(bus.zero), W'(ed == '0));
  endtask

  initial begin : stim_p
    int           busy;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    bus.in_valid  = 1'b0;
    bus.alu_op    = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.dest_reg  = '0;
    bus.wb_en     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_write_data", bus.write_data, W'(0));
    chk("rst_write_reg", W'(bus.write_reg), W'(0));
    rst = 1'b0;
    @(negedge clk);

    lit("add_wrap", 4'h0, 24'hFFFFFF, 24'h2, 2'd1, 1'b1, 24'h000001, 1'b1, 1'b0, busy);
    lit("slt", 4'h6, 24'hFFFFFF, 24'h1, 2'd2, 1'b1, 24'h1, 1'b1, 1'b0, busy);
    lit("sltu", 4'h7, 24'hFFFFFF, 24'h1, 2'd2, 1'b1, 24'h0, 1'b1, 1'b0, busy);
    lit("sll_big", 4'h8, 24'h00ABCD, 24'd24, 2'd3, 1'b1, 24'h0, 1'b1, 1'b0, busy);
    lit("srl_23", 4'h9, 24'h800000, 24'd23, 2'd3, 1'b1, 24'h1, 1'b1, 1'b0, busy);
    lit("sra_big", 4'hA, 24'h800000, 24'd30, 2'd3, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, busy);
    lit("reserved_e", 4'hE, 24'h5, 24'h6, 2'd1, 1'b1, 24'h0, 1'b0, 1'b1, busy);

    lit("mul", 4'hB, 24'd1000, 24'd3000, 2'd1, 1'b1, 24'h2DC6C0, 1'b1, 1'b0, busy);
    chk("mul_busy_cycles", W'(busy), W'(24));

`ifdef ALU_DIV_EN
    lit("divu", 4'hC, 24'd100, 24'd7, 2'd1, 1'b1, 24'd14, 1'b1, 1'b0, busy);
    chk("divu_busy_cycles", W'(busy), W'(24));
    lit("remu", 4'hD, 24'd100, 24'd7, 2'd2, 1'b1, 24'd2, 1'b1, 1'b0, busy);
    lit("divu_zero", 4'hC, 24'd55, 24'd0, 2'd1, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, busy);
    lit("remu_zero", 4'hD, 24'd55, 24'd0, 2'd1, 1'b1, 24'd55, 1'b1, 1'b0, busy);
`else
    lit("divu_off", 4'hC, 24'd100, 24'd7, 2'd1, 1'b1, 24'd0, 1'b0, 1'b1, busy);
    lit("remu_off", 4'hD, 24'd100, 24'd7, 2'd1, 1'b1, 24'd0, 1'b0, 1'b1, busy);
`endif

    // Abort a multiply 10 cycles in
    send(4'hB, 24'd1000, 24'd3000, 2'd1, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", W'(bus.in_ready), W'(1));
    chk("abort_out_valid", W'(bus.out_valid), W'(0));
    repeat (30) @(negedge clk);
    lit("add_after_abort", 4'h0, 24'd3, 24'd4, 2'd1, 1'b1, 24'd7, 1'b1, 1'b0, busy);

    lit("add_dest0", 4'h0, 24'd5, 24'd6, 2'd0, 1'b1, 24'd11, 1'b0, 1'b0, busy);

    // Three back-to-back adds give three consecutive pulses
    for (int i = 0; i < 3; i++) begin
      chk("b2b_in_ready", W'(bus.in_ready), W'(1));
      bus.in_valid  = 1'b1;
      bus.alu_op    = 4'h0;
      bus.operand_a = W'(10 * i);
      bus.operand_b = W'(1);
      bus.dest_reg  = 2'd3;
      bus.wb_en     = 1'b1;
      @(negedge clk);
      chk("b2b_out_valid", W'(bus.out_valid), W'(1));
      chk("b2b_data", bus.write_data, W'(10 * i + 1));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Randomized traffic, scoreboard does the checking
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = W'($urandom_range(0, 300));
        1: a = W'($urandom);
        2: a = MASK;
        default: a = W'($urandom) | 24'h800000;
      endcase
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(0, 40));
        1: b = W'($urandom);
        2: b = '0;
        default: b = MASK;
      endcase
      send(op, a, b, RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    chk("drain_empty", W'(sbq.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
